// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bundle: pipeline control, imem read port and fetch->decode word
interface fetch_if;
    logic        halt;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        imem_fault;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        bubble_out;
    logic [7:0]  exc_out;
    logic        fetch_idle;

    modport master (
        input  halt, stall, flush, flush_pc, imem_data, imem_fault,
        output imem_addr, imem_rd, instr_out, pc_out, bubble_out, exc_out, fetch_idle
    );

    modport slave (
        output halt, stall, flush, flush_pc, imem_data, imem_fault,
        input  imem_addr, imem_rd, instr_out, pc_out, bubble_out, exc_out, fetch_idle
    );
endinterface

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage with skid buffer, flush redirect and fetch exceptions
module fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [7:0]  EXC_IFAULT   = 8'h82,
    parameter logic [7:0]  EXC_MISALIGN = 8'h84
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clk_en,
    fetch_if.master bus
);
    typedef enum logic {FETCH, WAIT_FLUSH} mode_t;

    mode_t       mode_q, mode_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_mis_q, resp_mis_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [7:0]  skid_exc_q, skid_exc_d;

    logic [7:0]  live_exc;
    logic [31:0] live_instr;
    logic [31:0] sel_instr, sel_pc;
    logic [7:0]  sel_exc;
    logic        bubble;
    logic        issue;
    logic        consume;
    logic        aligned;

    // The live word is the memory response for resp_pc; a fault or misalign replaces the data.
    always_comb begin
        live_exc = 8'h00;
        if (resp_mis_q)
            live_exc = EXC_MISALIGN;
        else if (bus.imem_fault)
            live_exc = EXC_IFAULT;
        live_instr = (live_exc != 8'h00) ? 32'h0 : bus.imem_data;
    end

    always_comb begin
        sel_instr = live_instr;
        sel_pc    = resp_pc_q;
        sel_exc   = live_exc;
        if (skid_valid_q) begin
            sel_instr = skid_instr_q;
            sel_pc    = skid_pc_q;
            sel_exc   = skid_exc_q;
        end
        bubble = !(skid_valid_q || resp_valid_q) || bus.halt || (mode_q == WAIT_FLUSH);
        bus.instr_out  = bubble ? 32'h0 : sel_instr;
        bus.pc_out     = bubble ? 32'h0 : sel_pc;
        bus.exc_out    = bubble ? 8'h00 : sel_exc;
        bus.bubble_out = bubble;
    end

    assign aligned        = (fetch_pc_q[1:0] == 2'b00);
    assign issue          = (mode_q == FETCH) && !bus.halt && !bus.stall && !bus.flush
                            && (bus.exc_out == 8'h00);
    assign consume        = !bus.stall && !bus.halt && !bus.flush && !bubble;
    assign bus.imem_rd    = issue && aligned;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.fetch_idle = (mode_q == WAIT_FLUSH);

    always_comb begin
        mode_d       = mode_q;
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        resp_mis_d   = resp_mis_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_exc_d   = skid_exc_q;

        if (bus.flush) begin
            fetch_pc_d   = bus.flush_pc;
            resp_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            mode_d       = FETCH;
        end else if (bus.halt || bus.stall) begin
            // The memory only holds its data for one cycle, so park the live word before it goes.
            if (resp_valid_q && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = live_instr;
                skid_pc_d    = resp_pc_q;
                skid_exc_d   = live_exc;
            end
            resp_valid_d = 1'b0;
        end else begin
            skid_valid_d = 1'b0;
            if (consume && (bus.exc_out != 8'h00)) begin
                mode_d       = WAIT_FLUSH;
                resp_valid_d = 1'b0;
            end else if (issue && aligned) begin
                resp_valid_d = 1'b1;
                resp_mis_d   = 1'b0;
                resp_pc_d    = fetch_pc_q;
                fetch_pc_d   = fetch_pc_q + 32'd4;
            end else if (issue) begin
                resp_valid_d = 1'b1;
                resp_mis_d   = 1'b1;
                resp_pc_d    = fetch_pc_q;
            end else begin
                resp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= FETCH;
            fetch_pc_q   <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h0;
            resp_mis_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_exc_q   <= 8'h00;
        end else if (clk_en) begin
            mode_q       <= mode_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            resp_mis_q   <= resp_mis_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_exc_q   <= skid_exc_d;
        end
    end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage: the producer end of the fetch→decode interface. It owns the fetch PC and issues reads to the synchronous instruction memory. Each cycle it presents one aligned {instr, pc, bubble, exc} word to decode. A skid buffer holds that word across stall and halt, so every PC is delivered and consumed exactly once. Flush redirects, instruction-fetch faults and misaligned PCs are handled here before decode sees the word.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- EXC_IFAULT, 8'h82, exception code for imem_fault
- EXC_MISALIGN, 8'h84, exception code for fetch_pc[1:0] != 0
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  global enable; when 0, all registers hold
- halt  in  1  pipeline halt
- stall  in  1  decode not consuming this cycle
- flush  in  1  redirect request
- flush_pc  in  32  redirect target
- imem_addr  out  32  read address, equals fetch_pc
- imem_rd  out  1  read strobe
- imem_data  in  32  read data, valid exactly one cycle after the accepted imem_rd
- imem_fault  in  1  fault flag, aligned with imem_data
- instr_out  out  32  presented instruction
- pc_out  out  32  PC of presented instruction
- bubble_out  out  1  presented word is empty
- exc_out  out  8  exception carried with presented word
- fetch_idle  out  1  high in WAIT_FLUSH

## Operation
- State registers:
  - fetch_pc
  - resp_valid, resp_pc, resp_mis (misalign marker)
  - skid_valid, skid_instr, skid_pc, skid_exc
  - mode: FETCH or WAIT_FLUSH
- Presented word, combinational:
  - Source is skid when skid_valid; otherwise the live response when resp_valid.
  - Live exc = resp_mis ? EXC_MISALIGN : imem_fault ? EXC_IFAULT : 0.
  - Live instr = 0 if exc != 0, else imem_data.
  - If no source is valid, or halt=1: bubble_out=1 and instr_out, pc_out, exc_out = 0.
- A word is consumed at an enabled edge with !stall && !halt && !flush && bubble_out=0.
- issue = mode==FETCH && !halt && !stall && !flush && presented exc==0.
  - imem_rd = issue && fetch_pc[1:0]==0.
  - imem_addr = fetch_pc always.
- Edge update when clk_en=1, in priority order:
  - flush: fetch_pc<=flush_pc; resp_valid, skid_valid<=0; mode<=FETCH.
  - halt or stall: if resp_valid && !skid_valid, capture the live word into skid. resp_valid<=0; fetch_pc unchanged.
  - Otherwise:
    - skid_valid<=0.
    - If a consumed word has exc!=0: mode<=WAIT_FLUSH, resp_valid<=0.
    - Else, on issue with aligned PC: resp_valid<=1, resp_mis<=0, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32).
    - Else, on issue with misaligned PC: resp_valid<=1, resp_mis<=1, resp_pc<=fetch_pc, fetch_pc unchanged.
    - Else: resp_valid<=0.
- WAIT_FLUSH: imem_rd=0, bubble_out=1; exited only by flush or rst.
- Reset values:
  - fetch_pc=RESET_PC; resp_valid=0, skid_valid=0; mode=FETCH.
  - Outputs: bubble_out=1, instr_out=0, pc_out=0, exc_out=0, imem_rd=1, imem_addr=RESET_PC, fetch_idle=0.
- Reset mid-stall or mid-flush discards skid and in-flight data immediately (asynchronous).

## Timing
- Fetch latency: request at edge N, word presented in cycle N+1, consumed at edge N+1 if !stall.
- Steady state delivers one word per cycle with no bubbles.
- Stall beginning at cycle S with pc P presented:
  - P is held through every stall cycle and the release cycle.
  - imem_rd=0 while stalled.
  - The first cycle after release presents P+4.
  - No bubble and no duplicate.
- Flush asserted in cycle F: bubble in F (forced by decode) and F+1; flush_pc presented in F+2.
- Misaligned target: no memory read; exception word presented with the same latency as a normal fetch.
- stall and flush together: flush wins.
- halt: identical to stall, but bubble_out is forced to 1.
- clk_en=0: state holds, and imem_data holds because memory shares clk_en.

## Test plan
- Reset with RESET_PC=0, no stall: imem_rd=1 with imem_addr=0 in cycle 0; pc_out=0,4,8,... from cycle 1; bubble_out=1 only in cycle 0.
- Stall for 3 cycles while pc 8 is presented: pc_out=8 with constant instr for 4 cycles; imem_rd=0 during the stall; next cycle pc_out=12; each PC consumed once.
- Flush to 0x100 in cycle F: bubble_out=1 in F+1; pc_out=0x100 in F+2, 0x104 in F+3.
- imem_fault on word 0x10: pc_out=0x10, exc_out=0x82, instr_out=0, bubble_out=0. Thereafter bubble_out=1, imem_rd=0, fetch_idle=1 until flush to 0x200 resumes fetch at 0x200.
- Flush to 0x102: imem_rd=0; in F+2 pc_out=0x102, exc_out=0x84; then WAIT_FLUSH.
- Stall and flush together in one cycle, then rst pulsed during a later stall: flush takes effect with the skid discarded; rst immediately gives bubble_out=1, and fetch restarts at RESET_PC.
